// File: rtl/instr_link_arbiter_pkg.sv
// Shared definitions for the instruction link arbiter and its round-robin
// picker: FSM state type and default parameter values.
// The optional frame watchdog is enabled by defining INSTR_ARB_TIMEOUT_EN
// at build time (disabled by default).
package instr_link_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_XFER  = 2'd3
  } arb_state_e;

  localparam int unsigned DEF_NUM_SRC    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_FRAME_LEN  = 4;
  localparam int unsigned DEF_TIMEOUT    = 16;

endpackage

// File: rtl/instr_link_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Scans req starting at ptr+1 (wrapping) and returns the first set index.
// Ports:
//   req    in  N   request vector
//   ptr    in  PW  index of the previous winner (lowest priority now)
//   winner out PW  selected index (0 when valid is low)
//   valid  out 1   at least one request is set
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          valid
);

  // Walk offsets from N (lowest priority, ptr itself) down to 1 (highest
  // priority, ptr+1); later hits overwrite earlier ones.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned   idx;
      logic [PW-1:0] sel;
      idx = (32'(ptr) + N - k) % N;
      sel = PW'(idx);
      if (req[sel]) begin
        winner = sel;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_link_arbiter.sv
// instr_link_arbiter: shares one downstream instruction link between
// NUM_SRC framing encoders. Requests are granted round-robin, one frame of
// FRAME_LEN words at a time, and the owner's words are registered onto
// out_en/out_data with one cycle of latency.
// Optional watchdog: define INSTR_ARB_TIMEOUT_EN to abort a frame after
// TIMEOUT cycles without an owner word; otherwise timeout is tied low.
// Ports:
//   sys_clk   in   clock, posedge
//   sys_rstn  in   asynchronous active-low reset
//   req       in   per-source frame request (level)
//   grant     out  one-hot single-cycle grant pulse
//   in_en     in   per-source word valid
//   in_data   in   per-source words, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_ready in   downstream can accept a full frame
//   out_en    out  output word valid
//   out_data  out  output word
//   busy      out  link owned
//   stray_err out  sticky: word seen from a non-owner or outside a frame
//   timeout   out  single-cycle pulse when a frame is aborted
module instr_link_arbiter
  import instr_link_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC    = DEF_NUM_SRC,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FRAME_LEN  = DEF_FRAME_LEN,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          sys_clk,
  input  logic                          sys_rstn,
  input  logic [NUM_SRC-1:0]            req,
  output logic [NUM_SRC-1:0]            grant,
  input  logic [NUM_SRC-1:0]            in_en,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] in_data,
  input  logic                          out_ready,
  output logic                          out_en,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          busy,
  output logic                          stray_err,
  output logic                          timeout
);

  localparam int unsigned PW = $clog2(NUM_SRC);
  localparam int unsigned CW = $clog2(FRAME_LEN + 1);

  if (NUM_SRC < 2 || NUM_SRC > 8 || FRAME_LEN < 1 || TIMEOUT < 1) begin : g_param_check
    $error("instr_link_arbiter: parameter out of range");
  end

  arb_state_e          state, state_nxt;
  logic [PW-1:0]       owner, ptr, winner;
  logic                win_valid;
  logic [CW-1:0]       word_cnt;
  logic [NUM_SRC-1:0]  owner_mask;
  logic                in_frame, own_word, last_word, start_grant, abort;

  rr_pick #(
    .N  (NUM_SRC),
    .PW (PW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  assign in_frame    = (state == ST_WAIT) || (state == ST_XFER);
  assign owner_mask  = NUM_SRC'(1) << owner;
  assign own_word    = in_frame && in_en[owner];
  assign last_word   = own_word && ((word_cnt + CW'(1)) == CW'(FRAME_LEN));
  assign start_grant = (state == ST_IDLE) && win_valid && out_ready;

`ifdef INSTR_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wdog;
  logic          timeout_q;

  // Counts silent cycles inside a frame; restarts on every owner word.
  assign abort = in_frame && !in_en[owner] && ((wdog + TW'(1)) == TW'(TIMEOUT));

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (!in_frame || own_word || abort) wdog <= '0;
      else                                wdog <= wdog + TW'(1);
    end
  end

  assign timeout = timeout_q;
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_grant) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = ST_WAIT;
      ST_WAIT, ST_XFER: begin
        if (last_word || abort) state_nxt = ST_IDLE;
        else if (own_word)      state_nxt = ST_XFER;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    grant = '0;
    busy  = (state != ST_IDLE);
    if (state == ST_GRANT) grant = owner_mask;
  end

  // Owner, round-robin pointer, word counter, datapath and error flag
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      owner     <= '0;
      ptr       <= PW'(NUM_SRC - 1);
      word_cnt  <= '0;
      out_en    <= 1'b0;
      out_data  <= '0;
      stray_err <= 1'b0;
    end else begin
      if (start_grant) begin
        owner <= winner;
        ptr   <= winner;
      end

      if (!in_frame || last_word) word_cnt <= '0;
      else if (own_word)          word_cnt <= word_cnt + CW'(1);

      out_en <= own_word;
      if (own_word) out_data <= in_data[owner*DATA_WIDTH +: DATA_WIDTH];

      // Only the owner may drive words, and only inside WAIT/XFER.
      if (|(in_en & ~(in_frame ? owner_mask : '0))) stray_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_link_arbiter.sv
// Self-checking bench for instr_link_arbiter. A behavioural model tracks
// link ownership per clock edge and predicts grants, output words, busy,
// stray_err and (when INSTR_ARB_TIMEOUT_EN is defined) timeout.
module tb_instr_link_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int FL = 4;
  localparam int TO = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rstn;
  logic [NS-1:0]     req_d, en_d;
  logic [NS*DW-1:0]  data_d;
  logic              rdy_d;
  logic [NS-1:0]     grant;
  logic              out_en, busy, stray_err, timeout;
  logic [DW-1:0]     out_data;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit            m_busy, m_stray;
  int            m_ptr, m_owner, m_age, m_words, m_idle;
  logic [NS-1:0] exp_grant;
  bit            exp_oen, exp_to;
  logic [DW-1:0] exp_odata;

  // Encoder models
  int enc_rem  [NS];
  bit enc_pend [NS];
  int grant_log[$];

  logic [DW-1:0] frame_words [FL];

  instr_link_arbiter #(
    .NUM_SRC    (NS),
    .DATA_WIDTH (DW),
    .FRAME_LEN  (FL),
    .TIMEOUT    (TO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rstn  (sys_rstn),
    .req       (req_d),
    .grant     (grant),
    .in_en     (en_d),
    .in_data   (data_d),
    .out_ready (rdy_d),
    .out_en    (out_en),
    .out_data  (out_data),
    .busy      (busy),
    .stray_err (stray_err),
    .timeout   (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_ref(input logic [NS-1:0] r, input int p);
    for (int k = 1; k <= NS; k++) begin
      int idx;
      idx = (p + k) % NS;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_stray = 0;
    m_ptr   = NS - 1;
    m_owner = 0;
    m_age   = 0;
    m_words = 0;
    m_idle  = 0;
    for (int i = 0; i < NS; i++) begin
      enc_rem[i]  = 0;
      enc_pend[i] = 0;
    end
  endtask

  // Applies one clock edge worth of inputs to the model.
  task automatic model_edge();
    exp_grant = '0;
    exp_oen   = 0;
    exp_to    = 0;
    if (!m_busy) begin
      if (|en_d) m_stray = 1;
      if (|req_d && rdy_d) begin
        int w;
        w = rr_ref(req_d, m_ptr);
        m_ptr = w; m_owner = w; m_busy = 1; m_age = 0; m_words = 0; m_idle = 0;
        exp_grant = NS'(1) << w;
      end
    end else if (m_age == 0) begin
      if (|en_d) m_stray = 1;
      m_age = 1;
    end else begin
      for (int i = 0; i < NS; i++)
        if (en_d[i] && i != m_owner) m_stray = 1;
      if (en_d[m_owner]) begin
        exp_oen   = 1;
        exp_odata = data_d[m_owner*DW +: DW];
        m_words++;
        m_idle = 0;
        if (m_words == FL) m_busy = 0;
      end else begin
`ifdef INSTR_ARB_TIMEOUT_EN
        m_idle++;
        if (m_idle == TO) begin
          m_busy = 0;
          exp_to = 1;
        end
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    check_val("grant", grant, exp_grant);
    check_val("busy", busy, m_busy);
    check_val("out_en", out_en, exp_oen);
    if (exp_oen) check_val("out_data", out_data, exp_odata);
    check_val("stray_err", stray_err, m_stray);
    check_val("timeout", timeout, exp_to);
  endtask

  task automatic apply_reset();
    sys_rstn = 1'b0;
    req_d = '0; en_d = '0; data_d = '0; rdy_d = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_val("rst_grant", grant, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_out_en", out_en, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_stray", stray_err, 0);
    check_val("rst_timeout", timeout, 0);
    sys_rstn = 1'b1;
    model_reset();
  endtask

  task automatic set_word(input int src, input logic [DW-1:0] w);
    en_d[src] = 1'b1;
    data_d[src*DW +: DW] = w;
  endtask

  task automatic run_traffic(input int cycles, input bit all_req);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NS; i++) begin
        en_d[i] = 1'b0;
        if (grant[i]) begin
          enc_pend[i] = 0;
          enc_rem[i]  = FL;
          grant_log.push_back(i);
        end else begin
          if (enc_rem[i] > 0 && (all_req || $urandom_range(3) != 0))
            set_word(i, $urandom);
          if (en_d[i]) enc_rem[i]--;
          if (!enc_pend[i] && enc_rem[i] == 0 && (all_req || $urandom_range(2) == 0))
            enc_pend[i] = 1;
          else if (enc_pend[i] && !all_req && $urandom_range(19) == 0)
            enc_pend[i] = 0;
        end
        req_d[i] = enc_pend[i];
      end
      rdy_d = all_req ? 1'b1 : ($urandom_range(3) != 0);
      step();
    end
    en_d = '0;
    req_d = '0;
  endtask

  initial begin
    int to_k, g_k;
    frame_words[0] = 32'hA5A5_0001;
    frame_words[1] = 32'h1234_5678;
    frame_words[2] = 32'h5A5A_0003;
    frame_words[3] = 32'hC0DE_CAFE;

    apply_reset();

    // Single frame from source 0
    rdy_d = 1'b1; req_d = 4'b0001;
    step();
    check_val("t1_grant", grant, 4'b0001);
    req_d = '0;
    step();
    for (int k = 0; k < FL; k++) begin
      en_d = '0;
      set_word(0, frame_words[k]);
      step();
      check_val("t1_word", out_data, frame_words[k]);
    end
    en_d = '0;
    step();
    check_val("t1_busy_after", busy, 0);
    check_val("t1_out_en_after", out_en, 0);

    // All sources requesting: strict rotation
    apply_reset();
    grant_log.delete();
    run_traffic(80, 1'b1);
    check_val("t2_count_ok", grant_log.size() >= 5, 1);
    for (int k = 0; k < 5; k++)
      check_val("t2_order", (k < grant_log.size()) ? grant_log[k] : -1, k % NS);

    // out_ready low blocks grants
    apply_reset();
    rdy_d = 1'b0; req_d = 4'b0100;
    repeat (5) step();
    check_val("t3_blocked", grant, 0);
    rdy_d = 1'b1;
    step();
    check_val("t3_grant", grant, 4'b0100);

    // Stray word from a non-owner
    apply_reset();
    rdy_d = 1'b1; req_d = 4'b0010;
    step();
    req_d = '0;
    step();
    en_d = '0; set_word(1, frame_words[0]);
    step();
    en_d = '0; set_word(1, frame_words[1]); set_word(3, 32'hDEAD_BEEF);
    step();
    check_val("t4_data", out_data, frame_words[1]);
    check_val("t4_stray", stray_err, 1);
    for (int k = 2; k < FL; k++) begin
      en_d = '0; set_word(1, frame_words[k]);
      step();
    end
    en_d = '0;
    repeat (3) step();
    check_val("t4_stray_held", stray_err, 1);

    // Silent owner
    apply_reset();
    rdy_d = 1'b1; req_d = 4'b1100;
    step();
    check_val("t5_grant", grant, 4'b0100);
    req_d = 4'b1000;
    step();
    to_k = -1; g_k = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (timeout && to_k < 0) to_k = k;
      if (grant == 4'b1000 && g_k < 0) g_k = k;
    end
`ifdef INSTR_ARB_TIMEOUT_EN
    check_val("t5_timeout_cycle", to_k, TO);
    check_val("t5_next_grant", g_k, TO + 1);
`else
    check_val("t5_busy_held", busy, 1);
    check_val("t5_no_timeout", to_k, -1);
    check_val("t5_no_regrant", g_k, -1);
`endif

    // Asynchronous reset during word 2
    apply_reset();
    rdy_d = 1'b1; req_d = 4'b0010;
    step();
    req_d = '0;
    step();
    en_d = '0; set_word(1, frame_words[0]);
    step();
    en_d = '0; set_word(1, frame_words[1]);
    #2 sys_rstn = 1'b0;
    #1;
    check_val("t6_out_en", out_en, 0);
    check_val("t6_out_data", out_data, 0);
    check_val("t6_busy", busy, 0);
    check_val("t6_grant", grant, 0);
    @(negedge sys_clk);
    en_d = '0;
    sys_rstn = 1'b1;
    model_reset();
    req_d = 4'b1111;
    step();
    check_val("t6_first_grant", grant, 4'b0001);

    // Randomised traffic
    apply_reset();
    run_traffic(600, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
